zeroheti_obi_rr_arbiter: RTL
============================

// Module: zeroheti_obi_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one OBI subordinate port (e.g. the APB bridge or HETIC
//  register port) between NumMgr OBI managers (core data, debug SBA, future DMA).
//  It allows one outstanding transaction and routes the response back to the owning manager.
//  It sits between the managers and a single crossbar or peripheral subordinate port.
// PARAMETERS
//  NumMgr     3   number of requesting managers (>=2)
//  AddrWidth  32  OBI address width
//  DataWidth  32  OBI data width; BE width = DataWidth/8
//  IdxWidth   derived (localparam): max(1,$clog2(NumMgr))
// PORTS
//  clk_i          in   1                 clock
//  rst_ni         in   1                 async active-low reset
//  mgr_req_i      in   NumMgr            per-manager OBI req
//  mgr_addr_i     in   NumMgr*AddrWidth  per-manager address
//  mgr_we_i       in   NumMgr            per-manager write enable
//  mgr_be_i       in   NumMgr*BE         per-manager byte enables
//  mgr_wdata_i    in   NumMgr*DataWidth  per-manager write data
//  mgr_gnt_o      out  NumMgr            per-manager grant, one-hot or zero
//  mgr_rvalid_o   out  NumMgr            per-manager rvalid, one-hot or zero
//  mgr_rdata_o    out  DataWidth         rdata broadcast to all managers
//  mgr_err_o      out  1                 err broadcast; qualified by mgr_rvalid_o
//  sbr_req_o      out  1                 request to the shared subordinate
//  sbr_addr_o/sbr_we_o/sbr_be_o/sbr_wdata_o  out  AddrWidth/1/BE/DataWidth  selected payload
//  sbr_gnt_i      in   1                 subordinate grant
//  sbr_rvalid_i   in   1                 subordinate response valid
//  sbr_rdata_i    in   DataWidth         subordinate read data
//  sbr_err_i      in   1                 subordinate error
//  owner_o        out  IdxWidth          index of the current/last selected manager
//  unexp_rsp_o    out  1                 1-cycle pulse on sbr_rvalid_i with no transaction outstanding
// BEHAVIOUR
//  Reset: FSM=IDLE; rr_ptr=NumMgr-1, so manager 0 wins first; sel_q=0; all outputs 0.
//  FSM states: IDLE, WAIT_GNT, WAIT_RSP.
//   IDLE: winner = first asserted mgr_req_i searching rr_ptr+1, rr_ptr+2, ... with modulo-NumMgr wrap.
//     If any request is asserted: sbr_req_o=1 with the winner's payload, sel_q<=winner.
//     sbr_gnt_i=1 same cycle: mgr_gnt_o[winner]=1 (combinational), go to WAIT_RSP.
//     Otherwise go to WAIT_GNT.
//   WAIT_GNT: the selection is locked (no re-arbitration). sbr_req_o=1 with payload from sel_q.
//     On sbr_gnt_i: mgr_gnt_o[sel_q]=1 and go to WAIT_RSP.
//   WAIT_RSP: sbr_req_o=0 and all mgr_gnt_o=0.
//     On sbr_rvalid_i: mgr_rvalid_o[sel_q]=1, rr_ptr<=sel_q, go to IDLE.
//  Latency: 0 cycles req->gnt when idle and the subordinate grants immediately. Response is
//   combinational passthrough. The next arbitration happens in the cycle after rvalid, so the
//   minimum spacing is 2 cycles per transaction.
//  rr_ptr updates only on response completion. Index NumMgr-1 wraps to 0.
//  mgr_rdata_o=sbr_rdata_i and mgr_err_o=sbr_err_i at all times (unqualified broadcast).
//  sbr_rvalid_i in IDLE or WAIT_GNT: ignored (no mgr_rvalid_o), unexp_rsp_o=1 for 1 cycle, no state change.
//  sbr_gnt_i while sbr_req_o=0: ignored.
//  Manager dropping req or changing payload in WAIT_GNT is an OBI violation: payload is
//   forwarded live from sel_q and the violation is flagged by SVA only (non-synthesis).
//  owner_o=sel_q registered; holds its value in IDLE.
//  rst_ni asserted mid-transaction: immediate return to reset state. The in-flight response
//   is dropped; a later stray rvalid produces unexp_rsp_o.
// TESTING
//  1 Reset then mgr 0,1,2 req together, sbr_gnt_i=1, rvalid after 1 cycle -> served in order
//    0,1,2, each gnt one-hot, owner_o=0,1,2.
//  2 mgr 1 and 2 held high continuously -> grants alternate 1,2,1,2; mgr 0 never granted.
//  3 sbr_gnt_i held low 3 cycles while mgr 2 raises req during WAIT_GNT -> mgr 0 stays selected,
//    sbr_addr_o stable, gnt to mgr 0 in the 4th cycle.
//  4 Read via mgr 1 with sbr_rdata_i=32'hDEAD_BEEF, sbr_err_i=1 -> only mgr_rvalid_o[1]=1,
//    mgr_err_o=1, mgr_rdata_o=32'hDEAD_BEEF.
//  5 sbr_rvalid_i pulsed in IDLE -> unexp_rsp_o=1 one cycle, all mgr_rvalid_o=0, FSM stays IDLE.
//  6 rst_ni low during WAIT_RSP, then rvalid after reset release -> outputs 0, unexp_rsp_o=1,
//    next grant goes to mgr 0.

Source files
------------

// File: rtl/zeroheti_obi_rr_arbiter_if.sv
// OBI bundle between NumMgr managers, the round-robin arbiter and one shared
// subordinate. Names are taken from the arbiter's point of view: mgr_* faces
// the managers and sbr_* faces the subordinate.
//   slave  : the arbiter itself (accepts manager requests, drives the subordinate)
//   master : the surrounding system (managers plus the subordinate model)
interface zeroheti_obi_rr_arbiter_if #(
    parameter int NumMgr    = 3,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
);
    localparam int BeWidth = DataWidth / 8;

    // manager side
    logic [NumMgr-1:0]           mgr_req;
    logic [NumMgr*AddrWidth-1:0] mgr_addr;
    logic [NumMgr-1:0]           mgr_we;
    logic [NumMgr*BeWidth-1:0]   mgr_be;
    logic [NumMgr*DataWidth-1:0] mgr_wdata;
    logic [NumMgr-1:0]           mgr_gnt;
    logic [NumMgr-1:0]           mgr_rvalid;
    logic [DataWidth-1:0]        mgr_rdata;
    logic                        mgr_err;

    // subordinate side
    logic                        sbr_req;
    logic [AddrWidth-1:0]        sbr_addr;
    logic                        sbr_we;
    logic [BeWidth-1:0]          sbr_be;
    logic [DataWidth-1:0]        sbr_wdata;
    logic                        sbr_gnt;
    logic                        sbr_rvalid;
    logic [DataWidth-1:0]        sbr_rdata;
    logic                        sbr_err;

    modport slave (
        input  mgr_req, mgr_addr, mgr_we, mgr_be, mgr_wdata,
        output mgr_gnt, mgr_rvalid, mgr_rdata, mgr_err,
        output sbr_req, sbr_addr, sbr_we, sbr_be, sbr_wdata,
        input  sbr_gnt, sbr_rvalid, sbr_rdata, sbr_err
    );

    modport master (
        output mgr_req, mgr_addr, mgr_we, mgr_be, mgr_wdata,
        input  mgr_gnt, mgr_rvalid, mgr_rdata, mgr_err,
        input  sbr_req, sbr_addr, sbr_we, sbr_be, sbr_wdata,
        output sbr_gnt, sbr_rvalid, sbr_rdata, sbr_err
    );
endinterface

// File: rtl/zeroheti_obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI subordinate port between NumMgr managers.
// One transaction is outstanding at a time; the response is routed back to
// the manager that issued it. The round-robin pointer advances only when a
// response completes, so a manager stalled on a grant keeps its turn.
module zeroheti_obi_rr_arbiter #(
    parameter int  NumMgr    = 3,
    parameter int  AddrWidth = 32,
    parameter int  DataWidth = 32,
    localparam int IdxWidth  = (NumMgr > 2) ? $clog2(NumMgr) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    zeroheti_obi_rr_arbiter_if.slave obi,
    output logic [IdxWidth-1:0] owner_o,
    output logic                unexp_rsp_o
);
    localparam int BeWidth = DataWidth / 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        WAIT_RSP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [IdxWidth-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxWidth-1:0] sel_q, sel_d;

    logic [IdxWidth-1:0] winner;
    logic                any_req;
    logic [IdxWidth-1:0] sel_idx;

    // per-manager payload split out of the packed buses
    logic [AddrWidth-1:0] addr_arr  [NumMgr];
    logic                 we_arr    [NumMgr];
    logic [BeWidth-1:0]   be_arr    [NumMgr];
    logic [DataWidth-1:0] wdata_arr [NumMgr];

    for (genvar g = 0; g < NumMgr; g++) begin : g_unpack
        assign addr_arr[g]  = obi.mgr_addr[g*AddrWidth +: AddrWidth];
        assign we_arr[g]    = obi.mgr_we[g];
        assign be_arr[g]    = obi.mgr_be[g*BeWidth +: BeWidth];
        assign wdata_arr[g] = obi.mgr_wdata[g*DataWidth +: DataWidth];
    end

    // Round-robin search: first requester after rr_ptr_q, wrapping modulo NumMgr.
    always_comb begin
        winner  = '0;
        any_req = |obi.mgr_req;
        for (int i = NumMgr; i >= 1; i--) begin
            // scanning from the far end lets the nearest requester overwrite
            int cand;
            cand = (int'(rr_ptr_q) + i) % NumMgr;
            if (obi.mgr_req[IdxWidth'(cand)]) begin
                winner = IdxWidth'(cand);
            end
        end
    end

    // While idle the payload follows the live winner; afterwards it is locked to sel_q.
    assign sel_idx = (state_q == IDLE) ? winner : sel_q;

    // State, pointer and selection registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rr_ptr_q <= IdxWidth'(NumMgr - 1);
            sel_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            sel_q    <= sel_d;
        end
    end

    // Next-state logic plus request, grant, response routing and stray-response flag.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        sel_d          = sel_q;
        obi.sbr_req    = 1'b0;
        obi.mgr_gnt    = '0;
        obi.mgr_rvalid = '0;
        unexp_rsp_o    = 1'b0;

        unique case (state_q)
            IDLE: begin
                unexp_rsp_o = obi.sbr_rvalid;
                if (any_req) begin
                    obi.sbr_req = 1'b1;
                    sel_d       = winner;
                    if (obi.sbr_gnt) begin
                        obi.mgr_gnt = NumMgr'(1) << winner;
                        state_d     = WAIT_RSP;
                    end else begin
                        state_d     = WAIT_GNT;
                    end
                end
            end
            WAIT_GNT: begin
                unexp_rsp_o = obi.sbr_rvalid;
                obi.sbr_req = 1'b1;
                if (obi.sbr_gnt) begin
                    obi.mgr_gnt = NumMgr'(1) << sel_q;
                    state_d     = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (obi.sbr_rvalid) begin
                    obi.mgr_rvalid = NumMgr'(1) << sel_q;
                    rr_ptr_d       = sel_q;
                    state_d        = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Forward the selected payload; zero it whenever no request is presented.
    always_comb begin
        obi.sbr_addr  = '0;
        obi.sbr_we    = 1'b0;
        obi.sbr_be    = '0;
        obi.sbr_wdata = '0;
        if (obi.sbr_req) begin
            obi.sbr_addr  = addr_arr[sel_idx];
            obi.sbr_we    = we_arr[sel_idx];
            obi.sbr_be    = be_arr[sel_idx];
            obi.sbr_wdata = wdata_arr[sel_idx];
        end
    end

    // Response data and error are broadcast; managers qualify them with rvalid.
    assign obi.mgr_rdata = obi.sbr_rdata;
    assign obi.mgr_err   = obi.sbr_err;
    assign owner_o       = sel_q;

`ifndef SYNTHESIS
    logic [AddrWidth+BeWidth+DataWidth:0] sel_pld;
    assign sel_pld = {addr_arr[sel_idx], we_arr[sel_idx], be_arr[sel_idx], wdata_arr[sel_idx]};

    // A manager waiting for its grant must keep req high and its payload stable.
    a_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == WAIT_GNT) |-> (obi.mgr_req[sel_q] && $stable(sel_pld)));

    a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(obi.mgr_gnt));

    a_rvalid_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(obi.mgr_rvalid));
`endif

endmodule
